// File: rtl/ssd_scan_decoder.sv
// Samples a multiplexed 8-digit seven-segment bus and stores a decoded code for each digit slot.
// Define SSD_ERR_COUNT_EN to add the saturating err_cnt output.
module ssd_scan_decoder #(
  parameter int unsigned SETTLE = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] An,
  input  logic [7:0] Cath,
  input  logic [2:0] rd_sel,
  input  logic       err_clr,
  output logic [4:0] rd_code,
  output logic       rd_valid,
  output logic       frame_done,
  output logic       scan_err
`ifdef SSD_ERR_COUNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_HOLD
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

  state_t          state_q, state_d;
  logic [7:0]      an_q, an_d;
  logic [7:0]      cath_q, cath_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0][4:0] slot_q, slot_d;
  logic [7:0]      valid_q, valid_d;
  logic [7:0]      mask_q, mask_d;
  logic            frame_done_q, frame_done_d;
  logic            scan_err_q, scan_err_d;
`ifdef SSD_ERR_COUNT_EN
  logic [7:0]      err_cnt_q, err_cnt_d;
`endif

  logic [7:0] an_low;
  logic       one_low;
  logic       multi_low;
  logic [5:0] dec;
  logic [7:0] mask_next;
  logic       err_event;

  // Returns {known, code}; unknown patterns map to 5'b11111.
  function automatic logic [5:0] decode(input logic [7:0] c);
    case (c)
      8'h02:   decode = {1'b1, 5'h00};
      8'h9E:   decode = {1'b1, 5'h01};
      8'h24:   decode = {1'b1, 5'h02};
      8'h0C:   decode = {1'b1, 5'h03};
      8'h98:   decode = {1'b1, 5'h04};
      8'h48:   decode = {1'b1, 5'h05};
      8'h40:   decode = {1'b1, 5'h06};
      8'h1E:   decode = {1'b1, 5'h07};
      8'h00:   decode = {1'b1, 5'h08};
      8'h08:   decode = {1'b1, 5'h09};
      8'h10:   decode = {1'b1, 5'h0A};
      8'hC0:   decode = {1'b1, 5'h0B};
      8'h62:   decode = {1'b1, 5'h0C};
      8'h84:   decode = {1'b1, 5'h0D};
      8'h60:   decode = {1'b1, 5'h0E};
      8'h70:   decode = {1'b1, 5'h0F};
      8'hFF:   decode = {1'b1, 5'h10};
      8'h88:   decode = {1'b1, 5'h11};
      8'h04:   decode = {1'b1, 5'h12};
      8'hE2:   decode = {1'b1, 5'h13};
      default: decode = {1'b0, 5'h1F};
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    an_d         = an_q;
    cath_d       = cath_q;
    cnt_d        = cnt_q;
    slot_d       = slot_q;
    valid_d      = valid_q;
    mask_d       = mask_q;
    frame_done_d = 1'b0;
    err_event    = 1'b0;
    an_low       = ~An;
    multi_low    = (an_low & (an_low - 8'd1)) != '0;
    one_low      = (an_low != '0) && !multi_low;
    dec          = decode(cath_q);
    mask_next    = mask_q | ~an_q;

    if (multi_low) begin
      err_event = 1'b1;
      state_d   = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (one_low) begin
            an_d    = An;
            cath_d  = Cath;
            cnt_d   = '0;
            state_d = S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (!one_low) begin
            state_d = S_IDLE;
          end else if (An != an_q || Cath != cath_q) begin
            an_d   = An;
            cath_d = Cath;
            cnt_d  = '0;
          end else if (cnt_q == SETTLE_LAST) begin
            state_d = S_CAPTURE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_CAPTURE: begin
          for (int unsigned i = 0; i < 8; i++) begin
            if (!an_q[i]) begin
              slot_d[3'(i)]  = dec[4:0];
              valid_d[3'(i)] = dec[5];
            end
          end
          err_event = !dec[5];
          // A completed frame clears the mask in the same edge that raises the pulse.
          if (mask_next == '1) begin
            mask_d       = '0;
            frame_done_d = 1'b1;
          end else begin
            mask_d = mask_next;
          end
          state_d = S_HOLD;
        end
        S_HOLD: begin
          if (An != an_q) begin
            if (!one_low) begin
              state_d = S_IDLE;
            end else begin
              an_d    = An;
              cath_d  = Cath;
              cnt_d   = '0;
              state_d = S_SETTLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    scan_err_d = err_event ? 1'b1 : (err_clr ? 1'b0 : scan_err_q);
`ifdef SSD_ERR_COUNT_EN
    err_cnt_d = err_clr ? '0 : err_cnt_q;
    if (err_event && err_cnt_d != '1) begin
      err_cnt_d = err_cnt_d + 8'd1;
    end
`endif
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      an_q         <= '1;
      cath_q       <= '1;
      cnt_q        <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        slot_q[3'(i)] <= 5'b10000;
      end
      valid_q      <= '0;
      mask_q       <= '0;
      frame_done_q <= 1'b0;
      scan_err_q   <= 1'b0;
`ifdef SSD_ERR_COUNT_EN
      err_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      an_q         <= an_d;
      cath_q       <= cath_d;
      cnt_q        <= cnt_d;
      slot_q       <= slot_d;
      valid_q      <= valid_d;
      mask_q       <= mask_d;
      frame_done_q <= frame_done_d;
      scan_err_q   <= scan_err_d;
`ifdef SSD_ERR_COUNT_EN
      err_cnt_q    <= err_cnt_d;
`endif
    end
  end

  assign rd_code    = slot_q[rd_sel];
  assign rd_valid   = valid_q[rd_sel];
  assign frame_done = frame_done_q;
  assign scan_err   = scan_err_q;
`ifdef SSD_ERR_COUNT_EN
  assign err_cnt    = err_cnt_q;
`endif

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Scoreboard bench for ssd_scan_decoder: transactions update a digit-level model, a monitor reads slots back.
module tb_ssd_scan_decoder;

  localparam int unsigned SETTLE = 4;

  logic       Clk;
  logic       Reset;
  logic [7:0] An;
  logic [7:0] Cath;
  logic [2:0] rd_sel;
  logic       err_clr;
  logic [4:0] rd_code;
  logic       rd_valid;
  logic       frame_done;
  logic       scan_err;
`ifdef SSD_ERR_COUNT_EN
  logic [7:0] err_cnt;
`endif

  ssd_scan_decoder #(.SETTLE(SETTLE)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .An         (An),
    .Cath       (Cath),
    .rd_sel     (rd_sel),
    .err_clr    (err_clr),
    .rd_code    (rd_code),
    .rd_valid   (rd_valid),
    .frame_done (frame_done),
    .scan_err   (scan_err)
`ifdef SSD_ERR_COUNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int         slot;
    logic [4:0] code;
    logic       valid;
    logic       err;
    int         cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   frames_exp = 0;
  int   frames_seen = 0;

  // Digit-level reference state.
  logic [4:0] m_slot[8];
  logic       m_valid[8];
  logic       m_err;
  int         m_cnt;
  logic [7:0] m_mask;

  logic [7:0] pat_tab[20] = '{8'h02, 8'h9E, 8'h24, 8'h0C, 8'h98, 8'h48, 8'h40, 8'h1E,
                              8'h00, 8'h08, 8'h10, 8'hC0, 8'h62, 8'h84, 8'h60, 8'h70,
                              8'hFF, 8'h88, 8'h04, 8'hE2};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic m_reset();
    for (int i = 0; i < 8; i++) begin
      m_slot[i]  = 5'b10000;
      m_valid[i] = 1'b0;
    end
    m_err  = 1'b0;
    m_cnt  = 0;
    m_mask = '0;
  endtask

  task automatic m_error();
    m_err = 1'b1;
    if (m_cnt < 255) m_cnt++;
  endtask

  // Table position is the code (0..19); anything else is unknown.
  task automatic m_capture(input int d, input logic [7:0] c);
    int idx = -1;
    for (int i = 0; i < 20; i++) if (pat_tab[i] == c) idx = i;
    if (idx >= 0) begin
      m_slot[d]  = 5'(idx);
      m_valid[d] = 1'b1;
    end else begin
      m_slot[d]  = 5'b11111;
      m_valid[d] = 1'b0;
      m_error();
    end
    m_mask[d] = 1'b1;
    if (m_mask == 8'hFF) begin
      frames_exp++;
      m_mask = '0;
    end
  endtask

  task automatic push(input int s);
    exp_t e;
    e.slot  = s;
    e.code  = m_slot[s];
    e.valid = m_valid[s];
    e.err   = m_err;
    e.cnt   = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(negedge Clk);
    if (exp_q.size() > 0) chk("scoreboard_drain", exp_q.size(), 0);
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] c, input int n);
    An   = a;
    Cath = c;
    repeat (n) @(negedge Clk);
  endtask

  task automatic idle(input int n);
    drive(8'hFF, 8'hFF, n);
  endtask

  function automatic logic [7:0] digit_an(input int d);
    return ~(8'h01 << d);
  endfunction

  function automatic logic [7:0] rand_cath();
    if ($urandom_range(0, 1) == 1) return pat_tab[$urandom_range(0, 19)];
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic scan(input int d, input logic [7:0] c);
    m_capture(d, c);
    drive(digit_an(d), c, SETTLE + 1);
    idle(2);
    push(d);
    drain();
  endtask

  task automatic glitch_scan(input int d, input logic [7:0] x, input logic [7:0] y, input int k);
    m_capture(d, y);
    drive(digit_an(d), x, k);
    drive(digit_an(d), y, SETTLE + 1);
    idle(2);
    push(d);
    drain();
  endtask

  task automatic multi_low(input logic [7:0] a);
    m_error();
    drive(a, rand_cath(), 1);
    idle(2);
    push($urandom_range(0, 7));
    drain();
  endtask

  task automatic clear_err();
    m_err = 1'b0;
    m_cnt = 0;
    err_clr = 1'b1;
    @(negedge Clk);
    err_clr = 1'b0;
    idle(1);
    push($urandom_range(0, 7));
    drain();
  endtask

  task automatic push_all();
    for (int i = 0; i < 8; i++) push(i);
    drain();
  endtask

  // Monitor: owns rd_sel and compares one scoreboard entry per cycle.
  initial begin
    exp_t e;
    rd_sel = '0;
    forever begin
      @(negedge Clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        rd_sel = 3'(e.slot);
        #1;
        chk($sformatf("rd_code[%0d]", e.slot), rd_code, e.code);
        chk($sformatf("rd_valid[%0d]", e.slot), rd_valid, e.valid);
        chk("scan_err", scan_err, e.err);
`ifdef SSD_ERR_COUNT_EN
        chk("err_cnt", err_cnt, 8'(e.cnt));
`endif
      end
    end
  end

  initial begin
    forever begin
      @(negedge Clk);
      if (frame_done === 1'b1) begin
        frames_seen++;
        chk("frame_done_unexpected", frames_seen <= frames_exp, 1);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a;
    int         kind;
    int         d;
    Reset = 1'b1;
    An = 8'hFF;
    Cath = 8'hFF;
    err_clr = 1'b0;
    m_reset();
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    chk("reset_frame_done", frame_done, 0);
    push_all();

    for (int i = 0; i < 8; i++) begin
      m_capture(i, 8'h88);
      drive(digit_an(i), 8'h88, SETTLE + 3);
    end
    idle(3);
    chk("frame_done_after_full_scan", frames_seen, 1);
    push_all();

    scan(0, 8'h9E);
    glitch_scan(2, 8'h24, 8'h0C, 2);
    multi_low(8'hFC);
    clear_err();
    scan(7, 8'hAA);
    clear_err();

    // Reset during the third settle cycle of slot 4 must leave the slot untouched.
    An = digit_an(4);
    Cath = 8'h98;
    repeat (3) @(posedge Clk);
    #2 Reset = 1'b1;
    #2 Reset = 1'b0;
    An = 8'hFF;
    Cath = 8'hFF;
    m_reset();
    @(negedge Clk);
    push_all();
    scan(4, 8'h98);

    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      d = $urandom_range(0, 7);
      if (kind <= 5) begin
        scan(d, rand_cath());
      end else if (kind <= 7) begin
        glitch_scan(d, rand_cath(), rand_cath(), $urandom_range(1, SETTLE));
      end else if (kind == 8) begin
        do a = 8'($urandom_range(0, 255)); while ($countones(~a) < 2);
        multi_low(a);
      end else begin
        clear_err();
      end
    end

    idle(3);
    chk("frame_done_total", frames_seen, frames_exp);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ssd_scan_decoder.md
SSD_SCAN_DECODER -- requirements
Module: ssd_scan_decoder

Interface
REQ-001 SHALL have parameter SETTLE, default 4: number of consecutive stable-input cycles required before a digit is captured; legal range 1..255.
REQ-002 SHALL have port Clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port An, input, 8: active-low anode enables; An[i] low selects digit i.
REQ-005 SHALL have port Cath, input, 8: active-low cathodes, ordered {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp} MSB to LSB.
REQ-006 SHALL have port rd_sel, input, 3: selects the digit slot to read.
REQ-007 SHALL have port err_clr, input, 1: synchronous clear of scan_err (and err_cnt when compiled in).
REQ-008 SHALL have port rd_code, output, 5: stored code of slot rd_sel; combinational read.
REQ-009 SHALL have port rd_valid, output, 1: slot rd_sel holds a decoded, known code.
REQ-010 SHALL have port frame_done, output, 1: one-cycle pulse when all 8 slots are captured in the current frame.
REQ-011 SHALL have port scan_err, output, 1: sticky protocol or decode error flag.

Function
REQ-012 SHALL decode Cath to a 5-bit code per the team SSD table:
- 0x02=0, 0x9E=1, 0x24=2, 0x0C=3, 0x98=4, 0x48=5, 0x40=6, 0x1E=7
- 0x00=8, 0x08=9, 0x10=A, 0xC0=B, 0x62=C, 0x84=D, 0x60=E, 0x70=F
- 0xFF=10000 (OFF), 0x88=10001 (Y), 0x04=10010 (a), 0xE2=10011 (L)
- any other pattern is unknown.
REQ-013 SHALL implement states IDLE, SETTLE, CAPTURE, HOLD.
REQ-014 IDLE: An==8'hFF; no capture. On exactly one An bit low, latch An and Cath, clear the settle counter, and go to SETTLE.
REQ-015 SETTLE: if An or Cath differs from the latched value, reload the latch and restart the count. After SETTLE consecutive equal cycles, go to CAPTURE.
REQ-016 CAPTURE, one cycle:
- write the decoded code into the selected slot;
- set the slot's valid bit to 1 for a known code, 0 for unknown (code written as 5'b11111);
- set the slot's bit in the frame mask;
- go to HOLD.
REQ-017 HOLD: remain until An changes. If the new An is all-high, go to IDLE; if one-hot-low, go to SETTLE with the new values.
REQ-018 If two or more An bits are low in any state: set scan_err, capture nothing, and go to IDLE.
REQ-019 An unknown cathode pattern at CAPTURE SHALL set scan_err.
REQ-020 When the frame mask becomes 8'hFF on a CAPTURE, frame_done SHALL pulse high in the next cycle and the mask SHALL clear in the same cycle as the pulse. Recapturing an already-masked slot SHALL overwrite the slot without affecting the mask.
REQ-021 Capture latency SHALL be SETTLE+1 cycles from the first stable cycle to the slot update; rd_code and rd_valid reflect the update the following cycle.
REQ-022 If err_clr and an error event occur in the same cycle, the set SHALL win.

Reset
REQ-023 On Reset, asynchronously:
- state = IDLE;
- all slots = 5'b10000 with valid = 0;
- frame mask = 0, settle counter = 0;
- frame_done = 0, scan_err = 0.
REQ-024 Reset asserted mid-SETTLE or mid-CAPTURE SHALL abort without writing any slot.

Configuration
REQ-025 With SSD_ERR_COUNT_EN defined, the block SHALL add output err_cnt, 8 bits: incremented on each error event (REQ-018, REQ-019), saturating at 255, cleared by Reset and err_clr. Without the macro, the port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-026 SETTLE=4; An=8'hFE, Cath=0x9E held 5 cycles -> slot 0 = 5'b00001, rd_valid=1 with rd_sel=0.
REQ-027 An=8'hFB, Cath=0x24 for 2 cycles, then Cath=0x0C held 5 cycles -> slot 2 = 5'b00011; value 2 is never stored.
REQ-028 Scan all 8 slots with Cath=0x88 -> frame_done pulses exactly once, one cycle after slot 7 capture; the mask then reads 0.
REQ-029 An=8'hFC (two digits low) -> scan_err=1, no slot written; err_clr -> scan_err=0. With SSD_ERR_COUNT_EN, err_cnt goes 0->1->0.
REQ-030 An=8'h7F, Cath=0xAA held -> slot 7 = 5'b11111, rd_valid=0, scan_err=1.
REQ-031 Reset asserted on the 3rd SETTLE cycle of slot 4 -> slot 4 = 5'b10000, rd_valid=0, state IDLE.
